mul_iter: RTL and testbench

Iterative radix-2 shift-add multiplier, 32×32→64, signed or unsigned: the multiply counterpart of the EXE-stage iterative divider. The EXE stage uses it for `mul.w`, `mulh.w` and `mulh.wu`. It takes operands through a valid/ready handshake and computes one partial product per cycle over a fixed 32 cycles. It holds the 64-bit product until the consumer accepts it, and can be cancelled at any time on a pipeline flush.

---
 rtl/mul_iter.sv | 92 +++++++++
 tb/tb_mul_iter.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/mul_iter.sv
// Iterative radix-2 shift-add multiplier, 32x32 -> 64, signed or unsigned.
// One partial product per cycle; the product is held until it is consumed.
module mul_iter (
    input  logic        clk,
    input  logic        resetn,
    input  logic        mul_valid,
    output logic        mul_ready,
    input  logic        mul_signed,
    input  logic [31:0] multiplicand,
    input  logic [31:0] multiplier,
    input  logic        cancel,
    output logic [63:0] result,
    output logic        complete,
    input  logic        result_ready
);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t      state;
    state_t      state_nx;
    logic [31:0] a_abs;
    logic [31:0] b_sh;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        neg;
    logic [5:0]  cnt;
    logic        accept;
    logic        last;
    logic [32:0] sum;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [63:0] prod;

    assign mul_ready = (state == IDLE);
    assign complete  = (state == DONE);
    assign accept    = mul_valid & mul_ready & ~cancel;
    assign last      = (cnt == 6'd32);

    // 0x80000000 negates to itself and is then read as unsigned 2^31
    assign op_a = (mul_signed & multiplicand[31]) ? -multiplicand : multiplicand;
    assign op_b = (mul_signed & multiplier[31])   ? -multiplier   : multiplier;

    assign sum  = {1'b0, hi} + (b_sh[0] ? {1'b0, a_abs} : 33'd0);
    assign prod = neg ? -{hi, lo} : {hi, lo};

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else         state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept)       state_nx = CALC;
            CALC:    if (last)         state_nx = DONE;
            DONE:    if (result_ready) state_nx = IDLE;
            default:                   state_nx = IDLE;
        endcase
        if (cancel) state_nx = IDLE;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            a_abs  <= 32'd0;
            b_sh   <= 32'd0;
            hi     <= 32'd0;
            lo     <= 32'd0;
            neg    <= 1'b0;
            cnt    <= 6'd0;
            result <= 64'd0;
        end else if (cancel) begin
            cnt <= 6'd0;
        end else if (accept) begin
            a_abs <= op_a;
            b_sh  <= op_b;
            neg   <= mul_signed & (multiplicand[31] ^ multiplier[31]);
            hi    <= 32'd0;
            lo    <= 32'd0;
            cnt   <= 6'd0;
        end else if (state == CALC) begin
            if (!last) begin
                hi   <= sum[32:1];
                lo   <= {sum[0], lo[31:1]};
                b_sh <= {1'b0, b_sh[31:1]};
                cnt  <= cnt + 6'd1;
            end else begin
                result <= prod;
            end
        end
    end

endmodule

// File: tb/tb_mul_iter.sv
// Self-checking bench for mul_iter: directed corner cases plus random
// operands compared against a plain-arithmetic product.
module tb_mul_iter;

    logic        clk = 1'b0;
    logic        resetn;
    logic        mul_valid;
    logic        mul_ready;
    logic        mul_signed;
    logic [31:0] multiplicand;
    logic [31:0] multiplier;
    logic        cancel;
    logic [63:0] result;
    logic        complete;
    logic        result_ready;

    int checks = 0;
    int failures = 0;

    mul_iter dut (
        .clk          (clk),
        .resetn       (resetn),
        .mul_valid    (mul_valid),
        .mul_ready    (mul_ready),
        .mul_signed   (mul_signed),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .cancel       (cancel),
        .result       (result),
        .complete     (complete),
        .result_ready (result_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] ref_mul(input logic s,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
        longint sa;
        longint sb;
        if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            return 64'(sa * sb);
        end
        return {32'd0, a} * {32'd0, b};
    endfunction

    task automatic accept_op(input logic s, input logic [31:0] a,
                             input logic [31:0] b);
        chk("ready_before_accept", 64'(mul_ready), 64'd1);
        mul_valid    = 1'b1;
        mul_signed   = s;
        multiplicand = a;
        multiplier   = b;
        @(posedge clk);
        @(negedge clk);
        mul_valid    = 1'b0;
        multiplicand = $urandom;
        multiplier   = $urandom;
        mul_signed   = $urandom_range(0, 1);
    endtask

    // Waits for complete; counting from the negedge after the accept edge,
    // complete must appear at the 33rd following negedge.
    task automatic run_op(input string tag, input logic s,
                          input logic [31:0] a, input logic [31:0] b,
                          input int hold, input bit pulse, input bit rr_early);
        int cycles;
        logic [63:0] exp;
        exp = ref_mul(s, a, b);
        accept_op(s, a, b);
        if (rr_early) result_ready = 1'b1;
        cycles = 0;
        while (!complete && cycles < 100) begin
            if (pulse) begin
                mul_valid    = $urandom_range(0, 1);
                multiplicand = $urandom;
                multiplier   = $urandom;
            end
            @(negedge clk);
            cycles++;
        end
        mul_valid = 1'b0;
        chk({tag, "_latency"}, 64'(cycles), 64'd33);
        chk({tag, "_result"}, result, exp);
        if (rr_early) begin
            @(negedge clk);
            result_ready = 1'b0;
            chk({tag, "_early_rr_idle"}, 64'(mul_ready), 64'd1);
            return;
        end
        for (int i = 0; i < hold; i++) begin
            if (pulse) mul_valid = $urandom_range(0, 1);
            @(negedge clk);
            if (!complete || result !== exp) begin
                chk({tag, "_hold"}, {result[62:0], complete}, {exp[62:0], 1'b1});
                break;
            end
        end
        mul_valid = 1'b0;
        if (hold > 0) chk({tag, "_held"}, result, exp);
        result_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        result_ready = 1'b0;
        chk({tag, "_released"}, {62'd0, complete, mul_ready}, 64'd1);
    endtask

    initial begin
        bit seen;
        logic [31:0] ra;
        logic [31:0] rb;
        logic        rs;
        resetn       = 1'b0;
        mul_valid    = 1'b0;
        mul_signed   = 1'b0;
        multiplicand = 32'd0;
        multiplier   = 32'd0;
        cancel       = 1'b0;
        result_ready = 1'b0;
        #1;
        chk("reset_state", {result, 2'b00} | 64'({complete, mul_ready}), 64'd1);
        chk("reset_result", result, 64'd0);
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);

        run_op("umax", 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 3, 0, 0);
        run_op("neg3x7", 1'b1, 32'hFFFFFFFD, 32'h00000007, 0, 0, 0);
        run_op("minxmin", 1'b1, 32'h80000000, 32'h80000000, 0, 0, 0);
        run_op("zero_min", 1'b1, 32'h00000000, 32'h80000000, 0, 0, 0);
        run_op("u_min_x2", 1'b0, 32'h80000000, 32'h00000002, 0, 0, 0);

        accept_op(1'b0, 32'h12345678, 32'h9ABCDEF0);
        repeat (9) @(negedge clk);
        cancel = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cancel = 1'b0;
        chk("cancel_idle", {62'd0, complete, mul_ready}, 64'd1);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (complete) seen = 1'b1;
        end
        chk("cancel_no_complete", 64'(seen), 64'd0);
        run_op("after_cancel", 1'b0, 32'd6, 32'd7, 0, 0, 0);

        run_op("backpressure", 1'b1, 32'h7FFFFFFF, 32'h80000001, 20, 1, 0);
        run_op("back_to_back", 1'b0, 32'hDEADBEEF, 32'h0000FFFF, 0, 0, 0);
        run_op("rr_early", 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, 1);

        cancel    = 1'b1;
        mul_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cancel    = 1'b0;
        mul_valid = 1'b0;
        chk("cancel_vs_valid", 64'(mul_ready), 64'd1);

        accept_op(1'b0, 32'd3, 32'd5);
        repeat (33) @(negedge clk);
        chk("drop_done", 64'(complete), 64'd1);
        cancel       = 1'b1;
        result_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cancel       = 1'b0;
        result_ready = 1'b0;
        chk("cancel_in_done", {62'd0, complete, mul_ready}, 64'd1);

        for (int k = 0; k < 6; k++) begin
            ra = $urandom;
            rb = $urandom;
            rs = $urandom_range(0, 1);
            run_op("random", rs, ra, rb, k, k[0], 0);
        end

        accept_op(1'b1, 32'hFFFFFFF0, 32'h00000010);
        repeat (10) @(negedge clk);
        #2 resetn = 1'b0;
        #1;
        chk("async_rst_flags", {62'd0, complete, mul_ready}, 64'd1);
        chk("async_rst_result", result, 64'd0);
        #1 resetn = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (complete) seen = 1'b1;
        end
        chk("async_rst_no_complete", 64'(seen), 64'd0);
        run_op("after_reset", 1'b1, 32'hFFFFFFFF, 32'd1, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

endmodule
